// File: rtl/nios_sys_cache_pkg.sv
// Shared types and helpers for the dual-port KNN cache buffer.
// Holds the clear-FSM state encoding, the collision counter width and a byte-lane merge helper.
package nios_sys_cache_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_t;

   localparam int COLL_CNT_W  = 16;

   // Widest word the merge helper handles; callers size-cast in and out.
   localparam int MERGE_MAX_W = 256;
   localparam int MERGE_MAX_B = MERGE_MAX_W / 8;

   function automatic logic [MERGE_MAX_W-1:0] merge_be(
      input logic [MERGE_MAX_W-1:0] base,
      input logic [MERGE_MAX_W-1:0] upd,
      input logic [MERGE_MAX_B-1:0] be
   );
      logic [MERGE_MAX_W-1:0] res;
      res = base;
      for (int i = 0; i < MERGE_MAX_B; i++) begin
         if (be[i]) res[8*i +: 8] = upd[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/nios_sys_cache_dp_if.sv
// Avalon-MM slave port bundle for one side of the dual-port cache buffer.
interface nios_sys_cache_dp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) ();
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                chipselect;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic                waitrequest;

   modport master (
      output address, byteenable, chipselect, read, write, writedata,
      input  readdata, readdatavalid, waitrequest
   );

   modport slave (
      input  address, byteenable, chipselect, read, write, writedata,
      output readdata, readdatavalid, waitrequest
   );
endinterface

// File: rtl/nios_sys_cache_dp_ram.sv
// Byte-enabled true-dual-port storage array with old-data registered reads and no reset.
// Callers guarantee port B never enables a lane port A writes at the same address.
module nios_sys_cache_dp_ram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic                clk,
   input  logic                we_a,
   input  logic                re_a,
   input  logic [ADDR_W-1:0]   addr_a,
   input  logic [DATA_W/8-1:0] be_a,
   input  logic [DATA_W-1:0]   wd_a,
   output logic [DATA_W-1:0]   q_a,
   input  logic                we_b,
   input  logic                re_b,
   input  logic [ADDR_W-1:0]   addr_b,
   input  logic [DATA_W/8-1:0] be_b,
   input  logic [DATA_W-1:0]   wd_b,
   output logic [DATA_W-1:0]   q_b
);
   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;

   logic [NB-1:0][7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (we_a && be_a[i]) mem[addr_a][i] <= wd_a[8*i +: 8];
         if (we_b && be_b[i]) mem[addr_b][i] <= wd_b[8*i +: 8];
      end
      // Outputs hold between reads so the top can present a stable readdata.
      if (re_a) q_a <= mem[addr_a];
      if (re_b) q_b <= mem[addr_b];
   end
endmodule

// File: rtl/nios_sys_cache_dp.sv
// Dual-port KNN cache buffer: clear engine, write-collision arbitration,
// mixed-port forwarding and a 1- or 2-cycle read pipeline around the storage array.
module nios_sys_cache_dp
   import nios_sys_cache_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 9,
   parameter int READ_LAT       = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   nios_sys_cache_dp_if.slave    port_a,
   nios_sys_cache_dp_if.slave    port_b,
   input  logic                  clear,
   output logic                  busy,
   output logic [COLL_CNT_W-1:0] collision_cnt
);
   localparam int NB = DATA_W / 8;

   clr_state_t            state_reg;
   logic                  busy_reg;
   logic [ADDR_W-1:0]     clr_addr_reg;
   logic [COLL_CNT_W-1:0] coll_reg;

   logic [ADDR_W-1:0] addr   [2];
   logic [NB-1:0]     be     [2];
   logic [NB-1:0]     eff_be [2];
   logic [DATA_W-1:0] wd     [2];
   logic [DATA_W-1:0] ram_q  [2];
   logic [1:0]        cs, rd_cmd, wr_cmd, wr, rd;
   logic              collide;

   assign addr[0] = port_a.address;    assign addr[1] = port_b.address;
   assign be[0]   = port_a.byteenable; assign be[1]   = port_b.byteenable;
   assign wd[0]   = port_a.writedata;  assign wd[1]   = port_b.writedata;
   assign cs      = {port_b.chipselect, port_a.chipselect};
   assign rd_cmd  = {port_b.read, port_a.read};
   assign wr_cmd  = {port_b.write, port_a.write};

   // A write strobed with a read wins; the read is dropped without a response.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_accept
         assign wr[gi] = cs[gi] & wr_cmd[gi] & ~busy_reg;
         assign rd[gi] = cs[gi] & rd_cmd[gi] & ~wr_cmd[gi] & ~busy_reg;
      end
   endgenerate

   assign collide   = wr[0] & wr[1] & (addr[0] == addr[1]);
   assign eff_be[0] = be[0];
   assign eff_be[1] = collide ? (be[1] & ~be[0]) : be[1];

   // The clear engine borrows port A; user commands are stalled while it runs.
   logic              ram_we_a;
   logic [ADDR_W-1:0] ram_addr_a;
   logic [NB-1:0]     ram_be_a;
   logic [DATA_W-1:0] ram_wd_a;

   assign ram_we_a   = busy_reg | wr[0];
   assign ram_addr_a = busy_reg ? clr_addr_reg : addr[0];
   assign ram_be_a   = busy_reg ? {NB{1'b1}} : be[0];
   assign ram_wd_a   = busy_reg ? '0 : wd[0];

   nios_sys_cache_dp_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk    (clk),
      .we_a   (ram_we_a),
      .re_a   (rd[0]),
      .addr_a (ram_addr_a),
      .be_a   (ram_be_a),
      .wd_a   (ram_wd_a),
      .q_a    (ram_q[0]),
      .we_b   (wr[1]),
      .re_b   (rd[1]),
      .addr_b (addr[1]),
      .be_b   (eff_be[1]),
      .wd_b   (wd[1]),
      .q_b    (ram_q[1])
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
         busy_reg     <= (CLEAR_ON_RESET != 0);
         clr_addr_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (clear) begin
                  state_reg    <= ST_CLEAR;
                  busy_reg     <= 1'b1;
                  clr_addr_reg <= '0;
               end
            end
            ST_CLEAR: begin
               clr_addr_reg <= clr_addr_reg + 1'b1;
               if (&clr_addr_reg) begin
                  state_reg <= ST_IDLE;
                  busy_reg  <= 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                        coll_reg <= '0;
      else if (collide && (coll_reg != '1)) coll_reg <= coll_reg + 1'b1;
   end

   assign busy          = busy_reg;
   assign collision_cnt = coll_reg;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         localparam int OTH = 1 - gi;

         logic              vld1_reg;
         logic              seen_reg;
         logic [NB-1:0]     fwd_be_reg;
         logic [DATA_W-1:0] fwd_data_reg;
         logic [DATA_W-1:0] merged;
         logic [DATA_W-1:0] rdata_out;
         logic              vld_out;

         // Capture the other port's same-cycle write lanes so the old-data RAM read can be patched.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               vld1_reg     <= 1'b0;
               seen_reg     <= 1'b0;
               fwd_be_reg   <= '0;
               fwd_data_reg <= '0;
            end else begin
               vld1_reg <= rd[gi];
               if (rd[gi]) begin
                  seen_reg     <= 1'b1;
                  fwd_be_reg   <= (wr[OTH] && (addr[OTH] == addr[gi])) ? eff_be[OTH] : '0;
                  fwd_data_reg <= wd[OTH];
               end
            end
         end

         assign merged = seen_reg
                       ? DATA_W'(merge_be(MERGE_MAX_W'(ram_q[gi]), MERGE_MAX_W'(fwd_data_reg),
                                          MERGE_MAX_B'(fwd_be_reg)))
                       : '0;

         if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] rd2_reg;
            logic              vld2_reg;
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  rd2_reg  <= '0;
                  vld2_reg <= 1'b0;
               end else begin
                  vld2_reg <= vld1_reg;
                  if (vld1_reg) rd2_reg <= merged;
               end
            end
            assign rdata_out = rd2_reg;
            assign vld_out   = vld2_reg;
         end else begin : g_lat1
            assign rdata_out = merged;
            assign vld_out   = vld1_reg;
         end

         if (gi == 0) begin : g_out_a
            assign port_a.readdata      = rdata_out;
            assign port_a.readdatavalid = vld_out;
            assign port_a.waitrequest   = busy_reg;
         end else begin : g_out_b
            assign port_b.readdata      = rdata_out;
            assign port_b.readdatavalid = vld_out;
            assign port_b.waitrequest   = busy_reg;
         end
      end
   endgenerate
endmodule

// File: tb/tb_nios_sys_cache_dp.sv
// Self-checking bench: READ_LAT=1 and READ_LAT=2 instances share one stimulus stream
// and are compared every cycle against a word-array reference model.
module tb_nios_sys_cache_dp;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          clr = 1'b0;
   logic          a_cs = 1'b0, a_rd = 1'b0, a_wr = 1'b0;
   logic          b_cs = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [3:0]    a_be = '0, b_be = '0;
   logic [DW-1:0] a_wd = '0, b_wd = '0;
   logic          busy1, busy2;
   logic [15:0]   coll1, coll2;

   always #5 clk = ~clk;

   nios_sys_cache_dp_if #(.DATA_W(DW), .ADDR_W(AW)) pa1 ();
   nios_sys_cache_dp_if #(.DATA_W(DW), .ADDR_W(AW)) pb1 ();
   nios_sys_cache_dp_if #(.DATA_W(DW), .ADDR_W(AW)) pa2 ();
   nios_sys_cache_dp_if #(.DATA_W(DW), .ADDR_W(AW)) pb2 ();

   assign pa1.chipselect = a_cs; assign pa1.read = a_rd; assign pa1.write = a_wr;
   assign pa1.address = a_addr;  assign pa1.byteenable = a_be; assign pa1.writedata = a_wd;
   assign pa2.chipselect = a_cs; assign pa2.read = a_rd; assign pa2.write = a_wr;
   assign pa2.address = a_addr;  assign pa2.byteenable = a_be; assign pa2.writedata = a_wd;
   assign pb1.chipselect = b_cs; assign pb1.read = b_rd; assign pb1.write = b_wr;
   assign pb1.address = b_addr;  assign pb1.byteenable = b_be; assign pb1.writedata = b_wd;
   assign pb2.chipselect = b_cs; assign pb2.read = b_rd; assign pb2.write = b_wr;
   assign pb2.address = b_addr;  assign pb2.byteenable = b_be; assign pb2.writedata = b_wd;

   nios_sys_cache_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_lat1 (
      .clk(clk), .reset_n(reset_n), .port_a(pa1.slave), .port_b(pb1.slave),
      .clear(clr), .busy(busy1), .collision_cnt(coll1));

   nios_sys_cache_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_lat2 (
      .clk(clk), .reset_n(reset_n), .port_a(pa2.slave), .port_b(pb2.slave),
      .clear(clr), .busy(busy2), .collision_cnt(coll2));

   // Observation index: 0 = lat1 A, 1 = lat1 B, 2 = lat2 A, 3 = lat2 B.
   logic          obs_v [4];
   logic [DW-1:0] obs_d [4];
   logic          obs_w [4];
   assign obs_v[0] = pa1.readdatavalid; assign obs_d[0] = pa1.readdata; assign obs_w[0] = pa1.waitrequest;
   assign obs_v[1] = pb1.readdatavalid; assign obs_d[1] = pb1.readdata; assign obs_w[1] = pb1.waitrequest;
   assign obs_v[2] = pa2.readdatavalid; assign obs_d[2] = pa2.readdata; assign obs_w[2] = pa2.waitrequest;
   assign obs_v[3] = pb2.readdatavalid; assign obs_d[3] = pb2.readdata; assign obs_w[3] = pb2.waitrequest;

   // Reference model state
   logic [DW-1:0] mem [DEPTH];
   bit            m_busy;
   int            m_idx;
   logic [15:0]   m_coll;
   int            cyc;
   bit            pend_v [4][4];
   logic [DW-1:0] pend_d [4][4];
   logic [DW-1:0] last_d [4];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] apply_be(input logic [31:0] old, input logic [31:0] upd,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = upd[8*k +: 8];
      return r;
   endfunction

   task automatic push_read(input int i, input logic [31:0] data);
      int due;
      due = cyc + ((i < 2) ? 1 : 2) - 1;
      pend_v[i][due % 4] = 1'b1;
      pend_d[i][due % 4] = data;
   endtask

   task automatic model_reset();
      m_busy = 1'b1;
      m_idx  = 0;
      m_coll = 16'd0;
      for (int i = 0; i < 4; i++) begin
         last_d[i] = '0;
         for (int s = 0; s < 4; s++) pend_v[i][s] = 1'b0;
      end
   endtask

   // Effect of one rising edge with the inputs currently driven.
   task automatic model_update();
      bit wa, wb, ra, rb;
      cyc++;
      wa = a_cs && a_wr && !m_busy;
      wb = b_cs && b_wr && !m_busy;
      ra = a_cs && a_rd && !a_wr && !m_busy;
      rb = b_cs && b_rd && !b_wr && !m_busy;
      if (m_busy) mem[m_idx] = '0;
      // Port B first so port A's lanes overwrite it on a shared address.
      if (wb) mem[b_addr] = apply_be(mem[b_addr], b_wd, b_be);
      if (wa) mem[a_addr] = apply_be(mem[a_addr], a_wd, a_be);
      if (wa && wb && (a_addr == b_addr) && (m_coll != 16'hFFFF)) m_coll++;
      if (ra) begin push_read(0, mem[a_addr]); push_read(2, mem[a_addr]); end
      if (rb) begin push_read(1, mem[b_addr]); push_read(3, mem[b_addr]); end
      if (m_busy) begin
         m_idx++;
         if (m_idx == DEPTH) begin m_busy = 1'b0; m_idx = 0; end
      end else if (clr) begin
         m_busy = 1'b1;
         m_idx  = 0;
      end
   endtask

   task automatic check_outputs();
      int  slot;
      bit  exp_v;
      slot = cyc % 4;
      for (int i = 0; i < 4; i++) begin
         exp_v = 1'b0;
         if (pend_v[i][slot]) begin
            exp_v          = 1'b1;
            last_d[i]      = pend_d[i][slot];
            pend_v[i][slot] = 1'b0;
         end
         check_val($sformatf("rdvalid%0d", i), 32'(obs_v[i]), 32'(exp_v));
         check_val($sformatf("rdata%0d", i), obs_d[i], last_d[i]);
         check_val($sformatf("waitreq%0d", i), 32'(obs_w[i]), 32'(m_busy));
      end
      check_val("busy1", 32'(busy1), 32'(m_busy));
      check_val("busy2", 32'(busy2), 32'(m_busy));
      check_val("coll1", 32'(coll1), 32'(m_coll));
      check_val("coll2", 32'(coll2), 32'(m_coll));
   endtask

   // Called at a falling edge with inputs set; returns at the next falling edge after checking.
   task automatic step();
      model_update();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle();
      a_cs = 0; a_rd = 0; a_wr = 0; b_cs = 0; b_rd = 0; b_wr = 0; clr = 0;
   endtask

   task automatic set_a(input bit rd, input bit wr, input int addr, input logic [3:0] be,
                        input logic [31:0] wd);
      a_cs = 1; a_rd = rd; a_wr = wr; a_addr = AW'(addr); a_be = be; a_wd = wd;
      $display("[TB] port A rd=%0d wr=%0d addr=%0d be=%h data=%h", rd, wr, addr, be, wd);
   endtask

   task automatic set_b(input bit rd, input bit wr, input int addr, input logic [3:0] be,
                        input logic [31:0] wd);
      b_cs = 1; b_rd = rd; b_wr = wr; b_addr = AW'(addr); b_be = be; b_wd = wd;
      $display("[TB] port B rd=%0d wr=%0d addr=%0d be=%h data=%h", rd, wr, addr, be, wd);
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      #1;
      check_val("rst_busy1", 32'(busy1), 32'd1);
      check_val("rst_busy2", 32'(busy2), 32'd1);
      check_val("rst_coll1", 32'(coll1), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("rst_rdvalid%0d", i), 32'(obs_v[i]), 32'd0);
         check_val($sformatf("rst_rdata%0d", i), obs_d[i], 32'd0);
      end
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      $display("[TB] reset released at cycle %0d", cyc);
   endtask

   task automatic drain_clear();
      int guard;
      guard = 0;
      while (m_busy && guard < 100) begin step(); guard++; end
      check_val("clear_len_bound", 32'(guard < 100), 32'd1);
   endtask

   initial begin
      cyc = 0;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A5_0000 + 32'(i);
      @(negedge clk);
      do_reset();
      drain_clear();
      step();

      // Post-clear contents on both ports
      for (int a = 0; a < DEPTH; a++) begin
         set_a(1, 0, a, 4'h0, 32'h0);
         set_b(1, 0, DEPTH - 1 - a, 4'h0, 32'h0);
         step();
      end
      idle(); step(); step();

      // Byte-lane partial write
      set_a(0, 1, 5, 4'hF, 32'hAABBCCDD); step();
      set_a(0, 1, 5, 4'h1, 32'h00000011); step();
      set_a(1, 0, 5, 4'h0, 32'h0); step();
      idle(); step(); step();

      // Same-address dual write collision
      set_a(0, 1, 7, 4'h3, 32'h11111111);
      set_b(0, 1, 7, 4'hF, 32'h22222222); step();
      idle(); set_a(1, 0, 7, 4'h0, 32'h0); set_b(1, 0, 7, 4'h0, 32'h0); step();
      idle(); step(); step();

      // Mixed-port read during write
      set_a(0, 1, 3, 4'hF, 32'hDEADBEEF);
      set_b(1, 0, 3, 4'h0, 32'h0); step();
      idle(); step(); step();

      // Write held across a clear is stalled, then lands
      clr = 1; step(); clr = 0;
      set_a(0, 1, 2, 4'hF, 32'h5A5A1234);
      drain_clear();
      step();
      idle(); set_b(1, 0, 2, 4'h0, 32'h0); step();
      idle(); step(); step();

      // Reset with a READ_LAT=2 read still in flight
      set_a(1, 0, 2, 4'h0, 32'h0); set_b(1, 0, 7, 4'h0, 32'h0); step();
      do_reset();
      drain_clear();

      // Reset halfway through a requested clear
      set_a(0, 1, 9, 4'hF, 32'h01234567); step();
      idle(); clr = 1; step(); clr = 0;
      repeat (8) step();
      do_reset();
      drain_clear();
      idle(); set_a(1, 0, 9, 4'h0, 32'h0); step();
      idle(); step(); step();

      // Randomised traffic
      for (int n = 0; n < 1500; n++) begin
         a_cs   = ($urandom_range(0, 3) != 0);
         a_rd   = 1'($urandom_range(0, 1));
         a_wr   = ($urandom_range(0, 2) == 0);
         a_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 15));
         a_be   = 4'($urandom_range(0, 15));
         a_wd   = $urandom;
         b_cs   = ($urandom_range(0, 3) != 0);
         b_rd   = 1'($urandom_range(0, 1));
         b_wr   = ($urandom_range(0, 2) == 0);
         b_addr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 15));
         b_be   = 4'($urandom_range(0, 15));
         b_wd   = $urandom;
         clr    = ($urandom_range(0, 79) == 0);
         step();
      end
      idle();
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/nios_sys_cache_dp.md
# nios_sys_cache_dp

Parametrised true-dual-port on-chip buffer for the KNN accelerator. Both sides are Avalon-MM slaves on a single clock, with byte-enabled writes, a configurable pipelined read latency with `readdatavalid`, and deterministic write-collision and read-during-write rules. A zero-fill engine clears the array after reset or on demand so each query starts from a known-clean buffer. It is the successor to the fixed 512x32 cache instances between the Nios II and the distance/sort units.

## Interface
- `DATA_W`, 32: word width; must be a multiple of 8.
- `ADDR_W`, 9: address width; depth is 2**ADDR_W words.
- `READ_LAT`, 1: read latency in cycles; legal values are 1 and 2 (2 adds an output register).
- `CLEAR_ON_RESET`, 1: when 1, zero-fill the array automatically after reset release.
- `clk`  in  1  single clock for both ports and the clear engine.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`/`address2`  in  ADDR_W  word address, port A / port B.
- `byteenable`/`byteenable2`  in  DATA_W/8  byte lanes.
- `chipselect`/`chipselect2`  in  1  port select.
- `read`/`read2`, `write`/`write2`  in  1  command strobes.
- `writedata`/`writedata2`  in  DATA_W  write data.
- `readdata`/`readdata2`  out  DATA_W  read data.
- `readdatavalid`/`readdatavalid2`  out  1  read data qualifier.
- `waitrequest`/`waitrequest2`  out  1  high while a clear is running.
- `clear`  in  1  single-cycle pulse that requests a zero-fill.
- `busy`  out  1  clear engine is active.
- `collision_cnt`  out  16  saturating count of same-address dual writes.

## Operation
- A command on port X is accepted when `chipselect & (read|write) & !waitrequest`.
- Write: each enabled byte lane is updated; disabled lanes are unchanged.
- Read and write strobed together on one port: the write is performed and the read is dropped, so no `readdatavalid` is produced.
- Both ports write the same address in the same cycle:
  - Port A wins on the lanes both ports enable.
  - Port B's non-overlapping lanes are still written.
  - `collision_cnt` increments and saturates at 0xFFFF.
- Mixed-port read-during-write (port X reads the address port Y writes in that cycle): the returned word is new data, forwarded per byte lane.
- Same-port write followed by a read of that address on the next cycle returns the new data.
- Clear FSM states:
  - `IDLE` → `CLEAR` on reset release when `CLEAR_ON_RESET`=1, or on `clear` while in `IDLE`.
  - `CLEAR` writes zero to addresses 0..2**ADDR_W−1, one per cycle, driven by an ADDR_W-bit counter.
  - `CLEAR` → `IDLE` after the write to the last address.
  - `clear` is ignored while in `CLEAR`.
- Commands presented during `CLEAR` are stalled by `waitrequest`, never dropped.
- Read commands already in the pipeline when a clear starts complete with pre-clear data.

## Timing
- Reset values:
  - `readdata*` = 0, `readdatavalid*` = 0, `collision_cnt` = 0.
  - `busy` and `waitrequest*` = `CLEAR_ON_RESET`.
  - FSM in `CLEAR` at address 0 if `CLEAR_ON_RESET`=1, otherwise `IDLE`.
- Read accepted in cycle T: `readdatavalid` is high with data in cycle T+READ_LAT for exactly one cycle. Back-to-back reads give one result per cycle.
- Read data reflects the array contents at cycle T plus same-cycle forwarding. A write in T+1 does not alter a READ_LAT=2 result.
- `readdata` holds its last value when `readdatavalid` is low.
- Clear duration:
  - `busy` and `waitrequest*` rise the cycle after the `clear` pulse.
  - They stay high for exactly 2**ADDR_W cycles and fall the cycle after the last-address write.
- Reset asserted mid-clear or mid-read: all outputs return to their reset values immediately. In-flight reads are discarded; with `CLEAR_ON_RESET`=1 the clear restarts from address 0.

## Structure
- Shared package `nios_sys_cache_pkg` holds:
  - the clear-FSM state enum (`ST_IDLE`, `ST_CLEAR`);
  - the collision counter width constant (16);
  - a helper function that merges two write words by byte enables.
- Sub-module `nios_sys_cache_dp_ram`: plain byte-enabled true-dual-port array, registered address, old-data read, no reset. It must infer block RAM.
- Top level owns the clear FSM, collision arbitration, forwarding muxes and the latency pipeline.

## Test plan
- `CLEAR_ON_RESET`=1, ADDR_W=4: release reset → `waitrequest` high for 16 cycles; then reads of addresses 0..15 on both ports return 0.
- Port A writes 0xAABBCCDD to address 5 with byteenable 0xF, then 0x11 with byteenable 0x1 → read returns 0xAABBCC11 at T+READ_LAT for READ_LAT = 1 and 2.
- Same cycle: A writes 0x11111111 with be 0x3 and B writes 0x22222222 with be 0xF, both to address 7 → read returns 0x22221111 and `collision_cnt` = 1.
- Port A writes 0xDEADBEEF to address 3 while port B reads address 3 → B gets 0xDEADBEEF one READ_LAT later.
- Pulse `clear` while port A holds a write to address 2 → write stalls 2**ADDR_W cycles, completes after the clear, and address 2 reads back the written value.
- Drop `reset_n` for one cycle halfway through a clear → `busy` re-asserts and the full clear restarts; no `readdatavalid` from reads issued before the reset.
